// File: rtl/abs_diff_err_acc.sv
// abs_diff_err_acc: pipelined error-statistics engine for approximate
// absolute-difference circuits. It computes the exact |a-b| for each accepted
// sample, compares it with the approximate circuit's result, and accumulates
// count / nonzero count / max / saturating sum over a programmed run of N
// samples.
//
// Handshake: a sample transfers on a clock edge where in_valid && in_ready.
// in_ready is high only in RUN while fewer than N samples have been accepted.
// It depends only on registered state, never on in_valid. in_valid is ignored
// whenever in_ready is low. There is no backpressure inside the pipeline.
module abs_diff_err_acc #(
    parameter int W  = 6,
    parameter int OW = 6,
    parameter int CW = 16,
    parameter int SW = 24,
    localparam int EW = (W > OW) ? W : OW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] num_samples,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [OW-1:0] approx,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] samples_done,
    output logic [CW-1:0] err_count,
    output logic [EW-1:0] err_max,
    output logic [SW-1:0] err_sum
);

    // Accumulator width: wide enough that adding one per-sample error to the
    // current sum can never wrap before the saturation compare.
    localparam int AW = ((SW > EW) ? SW : EW) + 1;
    localparam logic [AW-1:0] SUM_MAX = AW'({SW{1'b1}});

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] n_q;
    logic [CW-1:0] acc_cnt;

    logic          v1;
    logic          v2;
    logic [W-1:0]  exact_q;
    logic [OW-1:0] approx_q;
    logic [EW-1:0] err_q;

    logic          accept;
    logic          clear;
    logic [EW-1:0] exact_ext;
    logic [EW-1:0] approx_ext;
    logic [EW-1:0] err_next;
    logic [AW-1:0] sum_wide;

    assign in_ready = (state == RUN) && (acc_cnt != n_q);
    assign accept   = in_valid && in_ready;
    // A start outside RUN begins a new run and wipes the statistics.
    assign clear    = start && (state != RUN);

    // Per-sample error between the exact and approximate differences.
    always_comb begin
        exact_ext  = EW'(exact_q);
        approx_ext = EW'(approx_q);
        err_next   = (exact_ext >= approx_ext) ? (exact_ext - approx_ext)
                                               : (approx_ext - exact_ext);
    end

    // Candidate sum for the saturating accumulator.
    always_comb begin
        sum_wide = AW'(err_sum) + AW'(err_q);
    end

    // Run-control FSM: latches N, counts accepts, waits for pipeline drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            n_q     <= '0;
            acc_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        n_q     <= num_samples;
                        acc_cnt <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + 1'b1;
                    end
                    // Finish only once every accepted sample has been accumulated.
                    if ((acc_cnt == n_q) && !v1 && !v2) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Two-stage datapath: S1 exact |a-b| with approx delayed, S2 error.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            exact_q  <= '0;
            approx_q <= '0;
            err_q    <= '0;
        end else begin
            v1 <= accept;
            v2 <= v1;
            if (accept) begin
                exact_q  <= (a >= b) ? (a - b) : (b - a);
                approx_q <= approx;
            end
            if (v1) begin
                err_q <= err_next;
            end
        end
    end

    // Statistics accumulate on the edge after S2; cleared by reset or a new run.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            samples_done <= '0;
            err_count    <= '0;
            err_max      <= '0;
            err_sum      <= '0;
        end else if (v2) begin
            samples_done <= samples_done + 1'b1;
            if (err_q != '0) begin
                err_count <= err_count + 1'b1;
            end
            if (err_q > err_max) begin
                err_max <= err_q;
            end
            err_sum <= (sum_wide > SUM_MAX) ? SW'(SUM_MAX) : SW'(sum_wide);
        end
    end

endmodule

// File: tb/tb_abs_diff_err_acc.sv
// Bench for abs_diff_err_acc: a default instance (SW=24) and a narrow-sum
// instance (SW=4) share all inputs. A plain arithmetic model turns each
// accepted sample into its error and derives the expected statistics.
module tb_abs_diff_err_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_samples = '0;
    logic        in_valid = 1'b0;
    logic [5:0]  a = '0;
    logic [5:0]  b = '0;
    logic [5:0]  approx = '0;

    logic        in_ready, busy, done;
    logic [15:0] samples_done, err_count;
    logic [5:0]  err_max;
    logic [23:0] err_sum;

    logic        in_ready_s, busy_s, done_s;
    logic [15:0] samples_done_s, err_count_s;
    logic [5:0]  err_max_s;
    logic [3:0]  err_sum_s;

    int checks   = 0;
    int failures = 0;

    logic [5:0] exp_q[$];
    int sa[$];
    int sb[$];
    int sx[$];

    abs_diff_err_acc dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .approx(approx),
        .busy(busy), .done(done), .samples_done(samples_done),
        .err_count(err_count), .err_max(err_max), .err_sum(err_sum)
    );

    abs_diff_err_acc #(.SW(4)) dut_s (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready_s), .a(a), .b(b), .approx(approx),
        .busy(busy_s), .done(done_s), .samples_done(samples_done_s),
        .err_count(err_count_s), .err_max(err_max_s), .err_sum(err_sum_s)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_err(input int x, input int y, input int ap);
        int e;
        e = (x > y) ? x - y : y - x;
        return (e > ap) ? e - ap : ap - e;
    endfunction

    // Generic run: start with N=n, feed sa/sb/sx, drain, compare statistics.
    task automatic do_run(input string tag, input int n, input int gap_pct,
                          input bit flood, input bit poke_start);
        int idx, cnt, mx, nz, sum, exp_lat;
        bit take;
        exp_q.delete();
        idx = 0;
        start = 1'b1;
        num_samples = 16'(n);
        step();
        start = 1'b0;
        num_samples = 16'($urandom_range(0, 200));
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || samples_done !== 16'd0 ||
            err_count !== 16'd0 || err_max !== 6'd0 || err_sum !== 24'd0) begin
            $display("FAIL %s_start_clear: busy=%b done=%b sd=%0d ec=%0d em=%0d es=%0d want busy=1 done=0 stats=0",
                     tag, busy, done, samples_done, err_count, err_max, err_sum);
            failures++;
        end
        cnt = 0;
        while (idx < n && cnt < 1000) begin
            in_valid = ($urandom_range(1, 100) > gap_pct);
            a = 6'(sa[idx]);
            b = 6'(sb[idx]);
            approx = 6'(sx[idx]);
            if (poke_start && cnt == 0) begin
                start = 1'b1;
                num_samples = 16'd9;
            end else begin
                start = 1'b0;
            end
            take = in_valid;
            checks++;
            if (in_ready !== 1'b1) begin
                $display("FAIL %s_ready_high: in_ready=%b want 1 (accepted %0d of %0d)",
                         tag, in_ready, idx, n);
                failures++;
            end
            step();
            cnt++;
            if (take) begin
                exp_q.push_back(6'(ref_err(sa[idx], sb[idx], sx[idx])));
                idx++;
            end
        end
        start = 1'b0;
        checks++;
        if (idx < n) begin
            $display("FAIL %s_accept_timeout: accepted %0d want %0d", tag, idx, n);
            failures++;
        end
        // drain: in_ready must stay low, statistics follow the 3-edge latency
        cnt = 0;
        while (done !== 1'b1 && cnt < 50) begin
            in_valid = flood;
            a = 6'($urandom_range(0, 63));
            b = 6'($urandom_range(0, 63));
            approx = 6'($urandom_range(0, 63));
            checks++;
            if (in_ready !== 1'b0) begin
                $display("FAIL %s_ready_low: in_ready=%b want 0", tag, in_ready);
                failures++;
            end
            step();
            cnt++;
            if (n > 0 && cnt == 1) begin
                checks++;
                if (samples_done !== 16'(n - 1)) begin
                    $display("FAIL %s_latency_prev: samples_done=%0d want %0d", tag, samples_done, n - 1);
                    failures++;
                end
            end
            if (n > 0 && cnt == 2) begin
                checks++;
                if (samples_done !== 16'(n)) begin
                    $display("FAIL %s_latency_last: samples_done=%0d want %0d", tag, samples_done, n);
                    failures++;
                end
            end
        end
        exp_lat = (n > 0) ? 3 : 1;
        checks++;
        if (done !== 1'b1 || cnt != exp_lat || busy !== 1'b0) begin
            $display("FAIL %s_done_timing: done=%b busy=%b after %0d cycles want done=1 busy=0 after %0d",
                     tag, done, busy, cnt, exp_lat);
            failures++;
        end
        // model statistics
        mx = 0; nz = 0; sum = 0;
        foreach (exp_q[i]) begin
            if (int'(exp_q[i]) > mx) mx = int'(exp_q[i]);
            if (exp_q[i] != 0) nz++;
            sum += int'(exp_q[i]);
        end
        // statistics must hold through the DONE state
        for (int h = 0; h < 3; h++) begin
            checks++;
            if (samples_done !== 16'(exp_q.size()) || err_count !== 16'(nz) ||
                err_max !== 6'(mx) || err_sum !== 24'(sum) || done !== 1'b1) begin
                $display("FAIL %s_stats: sd=%0d ec=%0d em=%0d es=%0d done=%b want sd=%0d ec=%0d em=%0d es=%0d done=1",
                         tag, samples_done, err_count, err_max, err_sum, done,
                         exp_q.size(), nz, mx, sum);
                failures++;
            end
            checks++;
            if (samples_done_s !== 16'(exp_q.size()) || err_count_s !== 16'(nz) ||
                err_max_s !== 6'(mx) || err_sum_s !== 4'((sum > 15) ? 15 : sum)) begin
                $display("FAIL %s_stats_sw4: sd=%0d ec=%0d em=%0d es=%0d want sd=%0d ec=%0d em=%0d es=%0d",
                         tag, samples_done_s, err_count_s, err_max_s, err_sum_s,
                         exp_q.size(), nz, mx, (sum > 15) ? 15 : sum);
                failures++;
            end
            in_valid = $urandom_range(0, 1) == 1;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic load(input int x, input int y, input int ap);
        sa.push_back(x);
        sb.push_back(y);
        sx.push_back(ap);
    endtask

    task automatic clear_tables();
        sa.delete();
        sb.delete();
        sx.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || samples_done !== 16'd0 ||
            err_count !== 16'd0 || err_max !== 6'd0 || err_sum !== 24'd0 || err_sum_s !== 4'd0) begin
            $display("FAIL reset: rdy=%b busy=%b done=%b sd=%0d ec=%0d em=%0d es=%0d want all 0",
                     in_ready, busy, done, samples_done, err_count, err_max, err_sum);
            failures++;
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        clear_tables();
        load(5, 12, 7);
        do_run("single", 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        clear_tables();
        load(5, 12, 4);
        load(40, 10, 30);
        load(0, 63, 60);
        do_run("b2b", 3, 0, 1'b0, 1'b0);
        checks++;
        if (err_count !== 16'd2 || err_max !== 6'd3 || err_sum !== 24'd6) begin
            $display("FAIL b2b_known: ec=%0d em=%0d es=%0d want 2 3 6", err_count, err_max, err_sum);
            failures++;
        end
    endtask

    task automatic test_overrun();
        clear_tables();
        load(20, 3, 17);
        load(7, 9, 5);
        do_run("overrun", 2, 0, 1'b1, 1'b0);
    endtask

    task automatic test_zero();
        clear_tables();
        do_run("zero", 0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_saturate();
        clear_tables();
        for (int i = 0; i < 3; i++) load(0, 63, 0);
        do_run("sat", 3, 0, 1'b0, 1'b0);
        checks++;
        if (err_sum_s !== 4'd15 || err_max_s !== 6'd63 || err_count_s !== 16'd3 || err_sum !== 24'd189) begin
            $display("FAIL sat_known: es4=%0d em=%0d ec=%0d es24=%0d want 15 63 3 189",
                     err_sum_s, err_max_s, err_count_s, err_sum);
            failures++;
        end
    endtask

    task automatic test_random();
        int x, y, e;
        clear_tables();
        for (int i = 0; i < 25; i++) begin
            x = $urandom_range(0, 63);
            y = $urandom_range(0, 63);
            e = (x > y) ? x - y : y - x;
            load(x, y, ($urandom_range(0, 1) == 1) ? e : $urandom_range(0, 63));
        end
        do_run("random", 25, 30, 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        start = 1'b1;
        num_samples = 16'd5;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        a = 6'd0;
        b = 6'd50;
        approx = 6'd1;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || samples_done !== 16'd0 ||
            err_count !== 16'd0 || err_max !== 6'd0 || err_sum !== 24'd0) begin
            $display("FAIL mid_reset: rdy=%b busy=%b done=%b sd=%0d ec=%0d em=%0d es=%0d want all 0",
                     in_ready, busy, done, samples_done, err_count, err_max, err_sum);
            failures++;
        end
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (busy !== 1'b0 || samples_done !== 16'd0 || err_sum !== 24'd0) begin
            $display("FAIL mid_reset_flush: busy=%b sd=%0d es=%0d want 0 0 0", busy, samples_done, err_sum);
            failures++;
        end
        clear_tables();
        load(33, 1, 30);
        do_run("after_reset", 1, 0, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_zero();
        test_saturate();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
